// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between the encoder's m00_axi master and axi_mem_responder.
interface axi_mem_responder_if #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     s_axi_awid;
  logic [31:0]             s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ID_WIDTH-1:0]     s_axi_arid;
  logic [31:0]             s_axi_araddr;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [ID_WIDTH-1:0]     s_axi_rid;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word-addressed register memory; independent read and
// write FSMs share the array, reads see pre-write data on same-cycle collisions.
module axi_mem_responder #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic               axi_clk,
  input  logic               reset,
  axi_mem_responder_if.slave s_axi
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != 3'b010);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  w_state_e w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
  logic [IW-1:0] w_addr_q, w_addr_d;
  logic [7:0] aw_len_q, aw_len_d, w_beat_q, w_beat_d;
  logic aw_fixed_q, aw_fixed_d, aw_bad_q, aw_bad_d, w_err_q, w_err_d;
  logic mem_we;

  r_state_e r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [IW-1:0] r_addr_q, r_addr_d;
  logic [7:0] ar_len_q, ar_len_d, r_beat_q, r_beat_d;
  logic ar_fixed_q, ar_fixed_d, ar_bad_q, ar_bad_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.s_axi_awaddr[31:ADDR_WIDTH], s_axi.s_axi_awaddr[1:0],
                              s_axi.s_axi_araddr[31:ADDR_WIDTH], s_axi.s_axi_araddr[1:0]};

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      w_addr_q   <= '0;
      aw_len_q   <= '0;
      w_beat_q   <= '0;
      aw_fixed_q <= 1'b0;
      aw_bad_q   <= 1'b0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      w_addr_q   <= w_addr_d;
      aw_len_q   <= aw_len_d;
      w_beat_q   <= w_beat_d;
      aw_fixed_q <= aw_fixed_d;
      aw_bad_q   <= aw_bad_d;
      w_err_q    <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    w_addr_d   = w_addr_q;
    aw_len_d   = aw_len_q;
    w_beat_d   = w_beat_q;
    aw_fixed_d = aw_fixed_q;
    aw_bad_d   = aw_bad_q;
    w_err_d    = w_err_q;
    mem_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (s_axi.s_axi_awvalid) begin
        w_state_d  = W_DATA;
        aw_id_d    = s_axi.s_axi_awid;
        w_addr_d   = s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
        aw_len_d   = s_axi.s_axi_awlen;
        aw_fixed_d = (s_axi.s_axi_awburst == 2'b00);
        aw_bad_d   = burst_bad(s_axi.s_axi_awburst, s_axi.s_axi_awsize);
        w_beat_d   = '0;
        w_err_d    = 1'b0;
      end
      W_DATA: if (s_axi.s_axi_wvalid) begin
        // Gated by reset so a burst aborted by reset leaves no trailing write.
        mem_we = !aw_bad_q && !reset;
        if (s_axi.s_axi_wlast != (w_beat_q == aw_len_q)) w_err_d = 1'b1;
        if (w_beat_q == aw_len_q) begin
          w_state_d = W_RESP;
        end else begin
          w_beat_d = w_beat_q + 8'd1;
          if (!aw_fixed_q) w_addr_d = w_addr_q + IW'(1);
        end
      end
      W_RESP: if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.s_axi_awready = 1'b0;
    s_axi.s_axi_wready  = 1'b0;
    s_axi.s_axi_bvalid  = 1'b0;
    s_axi.s_axi_bid     = '0;
    s_axi.s_axi_bresp   = RESP_OKAY;
    if (!reset) begin
      unique case (w_state_q)
        W_IDLE: s_axi.s_axi_awready = 1'b1;
        W_DATA: s_axi.s_axi_wready  = 1'b1;
        W_RESP: begin
          s_axi.s_axi_bvalid = 1'b1;
          s_axi.s_axi_bid    = aw_id_q;
          s_axi.s_axi_bresp  = (aw_bad_q || w_err_q) ? RESP_SLVERR : RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
        if (s_axi.s_axi_wstrb[i]) mem[w_addr_q][8*i +: 8] <= s_axi.s_axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      r_addr_q   <= '0;
      ar_len_q   <= '0;
      r_beat_q   <= '0;
      ar_fixed_q <= 1'b0;
      ar_bad_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      r_addr_q   <= r_addr_d;
      ar_len_q   <= ar_len_d;
      r_beat_q   <= r_beat_d;
      ar_fixed_q <= ar_fixed_d;
      ar_bad_q   <= ar_bad_d;
      rdata_q    <= rdata_d;
    end
  end

  // The beat's data is fetched on the accepting edge so the next beat is ready without a bubble.
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    r_addr_d   = r_addr_q;
    ar_len_d   = ar_len_q;
    r_beat_d   = r_beat_q;
    ar_fixed_d = ar_fixed_q;
    ar_bad_d   = ar_bad_q;
    rdata_d    = rdata_q;
    unique case (r_state_q)
      R_IDLE: if (s_axi.s_axi_arvalid) begin
        r_state_d  = R_DATA;
        ar_id_d    = s_axi.s_axi_arid;
        r_addr_d   = s_axi.s_axi_araddr[ADDR_WIDTH-1:2];
        ar_len_d   = s_axi.s_axi_arlen;
        ar_fixed_d = (s_axi.s_axi_arburst == 2'b00);
        ar_bad_d   = burst_bad(s_axi.s_axi_arburst, s_axi.s_axi_arsize);
        r_beat_d   = '0;
        rdata_d    = ar_bad_d ? '0 : mem[r_addr_d];
      end
      R_DATA: if (s_axi.s_axi_rready) begin
        if (r_beat_q == ar_len_q) begin
          r_state_d = R_IDLE;
          rdata_d   = '0;
        end else begin
          r_beat_d = r_beat_q + 8'd1;
          if (!ar_fixed_q) r_addr_d = r_addr_q + IW'(1);
          rdata_d = ar_bad_q ? '0 : mem[r_addr_d];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.s_axi_arready = 1'b0;
    s_axi.s_axi_rvalid  = 1'b0;
    s_axi.s_axi_rid     = '0;
    s_axi.s_axi_rdata   = '0;
    s_axi.s_axi_rresp   = RESP_OKAY;
    s_axi.s_axi_rlast   = 1'b0;
    if (!reset) begin
      unique case (r_state_q)
        R_IDLE: s_axi.s_axi_arready = 1'b1;
        R_DATA: begin
          s_axi.s_axi_rvalid = 1'b1;
          s_axi.s_axi_rid    = ar_id_q;
          s_axi.s_axi_rdata  = rdata_q;
          s_axi.s_axi_rresp  = ar_bad_q ? RESP_SLVERR : RESP_OKAY;
          s_axi.s_axi_rlast  = (r_beat_q == ar_len_q);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder against a word-array memory model.
module tb_axi_mem_responder;
  localparam int NW = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ID_WIDTH(1), .DATA_WIDTH(32)) bus ();

  axi_mem_responder #(.ID_WIDTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_WORDS(1024)) dut (
    .axi_clk(clk),
    .reset  (rst),
    .s_axi  (bus.slave)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] model_mem [NW];
  bit          known     [NW];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  logic [31:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  logic        rd_id   [$];
  int rd_lat, rd_gaps, rd_stall_viol;
  bit rd_to;
  logic rd_after;

  function automatic bit is_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b10) || (burst == 2'b11) || (size != 3'b010);
  endfunction

  function automatic int widx(input logic [31:0] addr, input int b, input logic [1:0] burst);
    int base;
    base = int'(addr[11:2]);
    if (burst == 2'b00) return base;
    return (base + b) % NW;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input int early_last,
                           input int stop_after, output logic [1:0] bresp, output logic bid,
                           output int b_lat, output bit to);
    int n, w;
    to = 0; bresp = 2'b00; bid = 1'b0; b_lat = 0;
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = 8'(len);
    bus.s_axi_awsize = size; bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    tick();
    bus.s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (stop_after >= 0 && b == stop_after) begin
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
        return;
      end
      bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = wbuf[b]; bus.s_axi_wstrb = sbuf[b];
      bus.s_axi_wlast = (early_last >= 0) ? (b == early_last) : (b == len);
      n = 0;
      while (!bus.s_axi_wready && n < 50) begin tick(); n++; end
      if (n >= 50) to = 1;
      tick();
      if (!is_bad(burst, size)) begin
        w = widx(addr, b, burst);
        for (int i = 0; i < 4; i++)
          if (sbuf[b][i]) model_mem[w][8*i +: 8] = wbuf[b][8*i +: 8];
        if (sbuf[b] == 4'hF) known[w] = 1;
      end
    end
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    while (!bus.s_axi_bvalid && b_lat < 50) begin tick(); b_lat++; end
    if (b_lat >= 50) to = 1;
    bresp = bus.s_axi_bresp; bid = bus.s_axi_bid;
    tick();
  endtask

  // mode: 0 = rready always high, 1 = toggling 1/0, 2 = random
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic id, input int mode);
    int n, cyc, got;
    bit stalled, rr;
    logic [31:0] pd; logic [1:0] pr; logic pl;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    rd_lat = 0; rd_gaps = 0; rd_stall_viol = 0; rd_to = 0;
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = 8'(len);
    bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 50) begin tick(); n++; end
    if (n >= 50) rd_to = 1;
    tick();
    bus.s_axi_arvalid = 1'b0;
    cyc = 0; got = 0; stalled = 0; pd = '0; pr = '0; pl = 1'b0;
    while (got <= len && cyc < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2 == 0) : bit'($urandom_range(0, 1));
      if (bus.s_axi_rvalid) begin
        if (stalled && (bus.s_axi_rdata !== pd || bus.s_axi_rresp !== pr || bus.s_axi_rlast !== pl))
          rd_stall_viol++;
        bus.s_axi_rready = rr;
        if (rr) begin
          rd_data.push_back(bus.s_axi_rdata); rd_resp.push_back(bus.s_axi_rresp);
          rd_last.push_back(bus.s_axi_rlast); rd_id.push_back(bus.s_axi_rid);
          got++; stalled = 0;
        end else begin
          stalled = 1; pd = bus.s_axi_rdata; pr = bus.s_axi_rresp; pl = bus.s_axi_rlast;
        end
      end else begin
        if (got == 0) rd_lat++;
        else if (mode == 0) rd_gaps++;
        bus.s_axi_rready = rr;
        stalled = 0;
      end
      tick();
      cyc++;
    end
    bus.s_axi_rready = 1'b0;
    if (cyc >= 2000) rd_to = 1;
    rd_after = bus.s_axi_rvalid;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.s_axi_awvalid = 1'b1; bus.s_axi_arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid} !== 4'b0000)
        begin fails++; $display("FAIL reset_hold cycle %0d: aw/ar ready, b/r valid = %b, required 0000", c,
          {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_bvalid, bus.s_axi_rvalid}); end
    end
    rst = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    #1;
    checks++;
    if ({bus.s_axi_awready, bus.s_axi_arready} !== 2'b11) begin
      fails++; $display("FAIL reset_release: awready,arready = %b, required 11", {bus.s_axi_awready, bus.s_axi_arready});
    end
    tick();
  endtask

  task automatic test_incr;
    logic [1:0] bresp; logic bid; int b_lat; bit to;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin wbuf[i] = exp_d[i]; sbuf[i] = 4'hF; end
    axi_write(32'h000, 3, 2'b01, 3'b010, 1'b1, -1, -1, bresp, bid, b_lat, to);
    checks++;
    if (to || bresp !== 2'b00 || bid !== 1'b1) begin
      fails++; $display("FAIL incr_bresp: bresp=%b bid=%b timeout=%0d, required 00 1 0", bresp, bid, to);
    end
    checks++;
    if (b_lat !== 0) begin fails++; $display("FAIL incr_b_latency: %0d extra cycles, required 0", b_lat); end
    axi_read(32'h000, 3, 2'b01, 3'b010, 1'b1, 0);
    checks++;
    if (rd_to || rd_data.size() != 4 || rd_lat != 0 || rd_gaps != 0 || rd_after !== 1'b0) begin
      fails++; $display("FAIL incr_read_timing: beats=%0d lat=%0d gaps=%0d rvalid_after=%b to=%0d, required 4 0 0 0 0",
        rd_data.size(), rd_lat, rd_gaps, rd_after, rd_to);
    end
    for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00 || rd_id[i] !== 1'b1) begin
        fails++; $display("FAIL incr_read_beat%0d: data=%h last=%b resp=%b id=%b, required %h %b 00 1",
          i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], exp_d[i], (i == 3));
      end
    end
  endtask

  task automatic test_strobe;
    logic [1:0] bresp; logic bid; int b_lat; bit to;
    wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
    axi_write(32'h010, 0, 2'b01, 3'b010, 1'b0, -1, -1, bresp, bid, b_lat, to);
    wbuf[0] = 32'hAABB_CCDD; sbuf[0] = 4'b0101;
    axi_write(32'h010, 0, 2'b01, 3'b010, 1'b0, -1, -1, bresp, bid, b_lat, to);
    axi_read(32'h010, 0, 2'b01, 3'b010, 1'b0, 0);
    checks++;
    if (rd_data.size() != 1 || rd_data[0] !== 32'hFFBB_FFDD || rd_last[0] !== 1'b1) begin
      fails++; $display("FAIL strobe_merge: got %h beats=%0d, required FFBBFFDD in 1 beat", rd_data[0], rd_data.size());
    end
  endtask

  task automatic test_wrap_backpressure;
    logic [1:0] bresp; logic bid; int b_lat; bit to; int w;
    for (int i = 0; i < 128; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'hFF0, 127, 2'b01, 3'b010, 1'b0, -1, -1, bresp, bid, b_lat, to);
    checks++;
    if (to || bresp !== 2'b00) begin fails++; $display("FAIL wrap_write_resp: bresp=%b to=%0d, required 00 0", bresp, to); end
    axi_read(32'hFF0, 127, 2'b01, 3'b010, 1'b0, 1);
    checks++;
    if (rd_to || rd_data.size() != 128 || rd_stall_viol != 0 || rd_after !== 1'b0) begin
      fails++; $display("FAIL wrap_read_flow: beats=%0d stall_changes=%0d rvalid_after=%b to=%0d, required 128 0 0 0",
        rd_data.size(), rd_stall_viol, rd_after, rd_to);
    end
    for (int i = 0; i < rd_data.size(); i++) begin
      w = (12'h3FC + i) % NW;
      checks++;
      if (rd_data[i] !== model_mem[w] || rd_last[i] !== (i == 127)) begin
        fails++; $display("FAIL wrap_read_beat%0d: word %h data=%h last=%b, required %h %b",
          i, w, rd_data[i], rd_last[i], model_mem[w], (i == 127));
      end
    end
  endtask

  task automatic test_errors;
    logic [1:0] bresp; logic bid; int b_lat; bit to;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5A00_0000 + i; sbuf[i] = 4'hF; end
    axi_write(32'h100, 1, 2'b01, 3'b010, 1'b0, -1, -1, bresp, bid, b_lat, to);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hDEAD_0000 + i; end
    axi_write(32'h100, 1, 2'b10, 3'b010, 1'b1, -1, -1, bresp, bid, b_lat, to);
    checks++;
    if (bresp !== 2'b10 || bid !== 1'b1) begin fails++; $display("FAIL err_wrap_bresp: %b id %b, required 10 1", bresp, bid); end
    axi_read(32'h100, 1, 2'b01, 3'b010, 1'b0, 0);
    checks++;
    if (rd_data.size() != 2 || rd_data[0] !== 32'h5A00_0000 || rd_data[1] !== 32'h5A00_0001) begin
      fails++; $display("FAIL err_wrap_mem: %h %h, required 5a000000 5a000001", rd_data[0], rd_data[1]);
    end
    axi_write(32'h200, 3, 2'b01, 3'b010, 1'b0, 1, -1, bresp, bid, b_lat, to);
    checks++;
    if (bresp !== 2'b10 || to) begin fails++; $display("FAIL err_early_wlast: bresp=%b to=%0d, required 10 0", bresp, to); end
    axi_read(32'h200, 1, 2'b01, 3'b001, 1'b1, 0);
    checks++;
    if (rd_data.size() != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_data[0] !== 32'h0 ||
        rd_data[1] !== 32'h0 || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
      fails++; $display("FAIL err_arsize: beats=%0d resp=%b,%b data=%h,%h, required 2 beats 10,10 0,0",
        rd_data.size(), rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [1:0] bresp; logic bid; int b_lat; bit to;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0DE_0000 + i; sbuf[i] = 4'hF; end
    axi_write(32'h300, 3, 2'b01, 3'b010, 1'b0, -1, 2, bresp, bid, b_lat, to);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      checks++;
      if (bus.s_axi_bvalid !== 1'b0) begin fails++; $display("FAIL midreset_bvalid cycle %0d: %b, required 0", c, bus.s_axi_bvalid); end
    end
    axi_read(32'h300, 1, 2'b01, 3'b010, 1'b0, 0);
    checks++;
    if (rd_data.size() != 2 || rd_data[0] !== 32'hC0DE_0000 || rd_data[1] !== 32'hC0DE_0001) begin
      fails++; $display("FAIL midreset_mem: %h %h, required c0de0000 c0de0001", rd_data[0], rd_data[1]);
    end
    wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h9ABC_DEF0;
    axi_write(32'h308, 1, 2'b01, 3'b010, 1'b1, -1, -1, bresp, bid, b_lat, to);
    checks++;
    if (to || bresp !== 2'b00 || bid !== 1'b1 || b_lat != 0) begin
      fails++; $display("FAIL midreset_next_aw: bresp=%b bid=%b lat=%0d to=%0d, required 00 1 0 0", bresp, bid, b_lat, to);
    end
  endtask

  task automatic test_random;
    logic [1:0] bresp; logic bid; int b_lat; bit to;
    logic [31:0] addr; int len, w, r; logic [1:0] burst; logic [2:0] size; logic id; bit bad;
    logic [31:0] exp_v;
    for (int t = 0; t < 24; t++) begin
      addr = $urandom; len = $urandom_range(0, 15); id = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 11);
      burst = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 5) ? 2'b00 : 2'b01;
      size  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
      bad = is_bad(burst, size);
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = $urandom; sbuf[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      end
      axi_write(addr, len, burst, size, id, -1, -1, bresp, bid, b_lat, to);
      checks++;
      if (to || bresp !== (bad ? 2'b10 : 2'b00) || bid !== id) begin
        fails++; $display("FAIL rand%0d_bresp: bresp=%b bid=%b to=%0d, required %b %b 0", t, bresp, bid, to, bad ? 2'b10 : 2'b00, id);
      end
      axi_read(addr, len, burst, size, ~id, 2);
      checks++;
      if (rd_to || rd_data.size() != len + 1 || rd_stall_viol != 0) begin
        fails++; $display("FAIL rand%0d_flow: beats=%0d stall_changes=%0d to=%0d, required %0d 0 0",
          t, rd_data.size(), rd_stall_viol, rd_to, len + 1);
      end
      for (int i = 0; i < rd_data.size(); i++) begin
        w = widx(addr, i, burst);
        exp_v = bad ? 32'h0 : model_mem[w];
        if (bad || known[w]) begin
          checks++;
          if (rd_data[i] !== exp_v || rd_resp[i] !== (bad ? 2'b10 : 2'b00) || rd_last[i] !== (i == len) || rd_id[i] !== ~id) begin
            fails++; $display("FAIL rand%0d_beat%0d: data=%h resp=%b last=%b id=%b, required %h %b %b %b",
              t, i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp_v, bad ? 2'b10 : 2'b00, (i == len), ~id);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NW; i++) known[i] = 0;
    rst = 1'b1;
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = 3'b010;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b1;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = 3'b010;
    bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    test_reset();
    test_incr();
    test_strobe();
    test_wrap_backpressure();
    test_errors();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
